display_driver_scan: RTL and testbench



---
 rtl/display_driver_scan.sv | 178 +++++++++++++++++
 tb/tb_display_driver_scan.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_driver_scan.sv
// Score/status display driver: sequential double-dabble BCD conversion, multiplexed
// seven-segment scan with leading-zero blanking, and an animated status LED bar.
module display_driver_scan #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SCORE_W   = 16,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 12500000,
  parameter int unsigned LED_W     = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [SCORE_W-1:0] score_in,
  input  logic [1:0]         game_state_in,
  input  logic               blank_en,
  output logic [DIGITS-1:0]  seg_an_out,
  output logic [7:0]         seg_data_out,
  output logic [LED_W-1:0]   led_out,
  output logic               conv_busy
);

  localparam int unsigned BcdW   = 4 * DIGITS;
  localparam int unsigned CntW   = $clog2(SCORE_W + 1);
  localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned ScanW  = $clog2(SCAN_DIV);
  localparam int unsigned BlinkW = $clog2(BLINK_DIV);
  localparam logic [63:0] MaxScore = 64'(10 ** DIGITS) - 64'd1;
  localparam logic [LED_W-1:0] OuterPat = LED_W'(3) | (LED_W'(3) << (LED_W - 2));

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StCommit} conv_state_e;

  conv_state_e        state_q, state_d;
  logic [SCORE_W-1:0] shift_q, shift_d, last_q, last_d;
  logic [BcdW-1:0]    acc_q, acc_d, acc_adj, disp_q, disp_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    last_d  = last_q;
    acc_d   = acc_q;
    disp_d  = disp_q;
    cnt_d   = cnt_q;
    acc_adj = acc_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    unique case (state_q)
      StIdle: if (score_in != last_q) state_d = StLoad;
      StLoad: begin
        shift_d = score_in;
        last_d  = score_in;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        acc_d   = {acc_adj[BcdW-2:0], shift_q[SCORE_W-1]};
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntW'(SCORE_W - 1)) state_d = StCommit;
      end
      StCommit: begin
        // Scores beyond the display range pin to all nines
        disp_d  = (64'(last_q) > MaxScore) ? {DIGITS{4'h9}} : acc_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      last_q  <= '0;
      acc_q   <= '0;
      disp_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign conv_busy = (state_q != StIdle);

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 8'hC0;
      4'd1:    seg_decode = 8'hF9;
      4'd2:    seg_decode = 8'hA4;
      4'd3:    seg_decode = 8'hB0;
      4'd4:    seg_decode = 8'h99;
      4'd5:    seg_decode = 8'h92;
      4'd6:    seg_decode = 8'h82;
      4'd7:    seg_decode = 8'hF8;
      4'd8:    seg_decode = 8'h80;
      4'd9:    seg_decode = 8'h90;
      default: seg_decode = 8'hFF;
    endcase
  endfunction

  logic [ScanW-1:0]  scan_cnt_q;
  logic [IdxW-1:0]   idx_q;
  logic [DIGITS-1:0] blank_vec, an_d;
  logic [7:0]        seg_d;
  logic              upper_zero;

  always_comb begin
    blank_vec  = '0;
    upper_zero = 1'b1;
    // Walk down from the top digit; a digit blanks only while everything above it is zero
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      upper_zero   = upper_zero && (disp_q[4*i +: 4] == 4'd0);
      blank_vec[i] = upper_zero;
    end
    an_d  = ~(DIGITS'(1) << idx_q);
    seg_d = (blank_en && blank_vec[idx_q]) ? 8'hFF : seg_decode(disp_q[4*idx_q +: 4]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt_q   <= '0;
      idx_q        <= '0;
      seg_an_out   <= '1;
      seg_data_out <= 8'hFF;
    end else begin
      seg_an_out   <= an_d;
      seg_data_out <= seg_d;
      if (scan_cnt_q == ScanW'(SCAN_DIV - 1)) begin
        scan_cnt_q <= '0;
        idx_q      <= (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end
    end
  end

  logic [1:0]        gs_q;
  logic [BlinkW-1:0] blink_cnt_q;
  logic              phase_q;
  logic [LED_W-1:0]  chase_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gs_q        <= 2'b00;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      chase_q     <= LED_W'(1);
    end else if (game_state_in != gs_q) begin
      gs_q        <= game_state_in;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      chase_q     <= LED_W'(1);
    end else if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
      chase_q     <= {chase_q[LED_W-2:0], chase_q[LED_W-1]};
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  always_comb begin
    led_out = '0;
    case (gs_q)
      2'b01:   led_out = chase_q;
      2'b10:   led_out = phase_q ? OuterPat : '0;
      2'b11:   led_out = phase_q ? ~OuterPat : '0;
      default: led_out = '0;
    endcase
  end

endmodule

// File: tb/tb_display_driver_scan.sv
// Self-checking bench for display_driver_scan: vector table, randomized scores and LED
// states against an arithmetic model, plus latency, glitch and mid-conversion reset sequences.
module tb_display_driver_scan;

  localparam int unsigned DIGITS    = 4;
  localparam int unsigned SCORE_W   = 16;
  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned BLINK_DIV = 8;
  localparam int unsigned LED_W     = 8;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [SCORE_W-1:0] score_in;
  logic [1:0]         game_state_in;
  logic               blank_en;
  logic [DIGITS-1:0]  seg_an_out;
  logic [7:0]         seg_data_out;
  logic [LED_W-1:0]   led_out;
  logic               conv_busy;

  display_driver_scan #(
    .DIGITS    (DIGITS),
    .SCORE_W   (SCORE_W),
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV),
    .LED_W     (LED_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .score_in      (score_in),
    .game_state_in (game_state_in),
    .blank_en      (blank_en),
    .seg_an_out    (seg_an_out),
    .seg_data_out  (seg_data_out),
    .led_out       (led_out),
    .conv_busy     (conv_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [1:0] cur_gs;
  int led_k;

  typedef struct {
    int          score;
    bit          blank;
    logic [31:0] codes;  // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected segment codes straight from decimal arithmetic on the score
  function automatic logic [31:0] model_codes(input int score, input bit blank);
    logic [7:0] lut [10];
    logic [31:0] r;
    int v, p;
    lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    v = (score > 9999) ? 9999 : score;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = (blank && i > 0 && v < p) ? 8'hFF : lut[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] led_model(input logic [1:0] st, input int k);
    int step;
    step = k / int'(BLINK_DIV);
    case (st)
      2'b01:   return 8'(1 << (step % int'(LED_W)));
      2'b10:   return (step % 2 == 0) ? 8'hC3 : 8'h00;
      2'b11:   return (step % 2 == 0) ? 8'h3C : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check_codes(input logic [31:0] exp, input string tag);
    logic [31:0] got;
    logic [3:0]  seen;
    logic [3:0]  an_exp;
    got  = '1;
    seen = '0;
    repeat (DIGITS * SCAN_DIV + 2) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        an_exp = ~(4'(1) << d);
        if (seg_an_out == an_exp) begin
          got[8*d +: 8] = seg_data_out;
          seen[d]       = 1'b1;
        end
      end
    end
    chk({tag, " digits scanned"}, 32'(seen), 32'hF);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s d%0d", tag, d), 32'(got[8*d +: 8]), 32'(exp[8*d +: 8]));
    end
  endtask

  task automatic apply_score(input int s, input bit b);
    @(negedge clk);
    score_in = SCORE_W'(s);
    blank_en = b;
    repeat (SCORE_W + 5) @(negedge clk);
    chk("busy after conversion", 32'(conv_busy), 32'd0);
  endtask

  task automatic led_run(input logic [1:0] st, input int n);
    if (st != cur_gs) led_k = -1;
    game_state_in = st;
    cur_gs        = st;
    repeat (n) begin
      @(negedge clk);
      led_k++;
      chk($sformatf("led st%0d k%0d", st, led_k), 32'(led_out), 32'(led_model(st, led_k)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt, first_rise, s;
    bit b;
    logic [3:0] an_exp;

    vecs[0] = '{0,     1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[1] = '{1234,  1'b1, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[2] = '{12345, 1'b1, {8'h90, 8'h90, 8'h90, 8'h90}};
    vecs[3] = '{7,     1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hF8}};
    vecs[4] = '{7,     1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hF8}};
    vecs[5] = '{1005,  1'b1, {8'hF9, 8'hC0, 8'hC0, 8'h92}};
    vecs[6] = '{80,    1'b1, {8'hFF, 8'hFF, 8'h80, 8'hC0}};
    vecs[7] = '{10000, 1'b0, {8'h90, 8'h90, 8'h90, 8'h90}};
    vecs[8] = '{906,   1'b0, {8'hC0, 8'h90, 8'hC0, 8'h82}};
    vecs[9] = '{9999,  1'b1, {8'h90, 8'h90, 8'h90, 8'h90}};

    reset_n       = 1'b0;
    score_in      = '0;
    game_state_in = 2'b00;
    blank_en      = 1'b1;
    cur_gs        = 2'b00;
    led_k         = 0;
    repeat (3) @(negedge clk);
    chk("reset an", 32'(seg_an_out), 32'hF);
    chk("reset seg", 32'(seg_data_out), 32'hFF);
    chk("reset led", 32'(led_out), 32'h0);
    chk("reset busy", 32'(conv_busy), 32'h0);
    reset_n = 1'b1;

    // Score 0 with blanking: anodes walk E,D,B,7; only digit 0 lit
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      an_exp = ~(4'(1) << ((k / int'(SCAN_DIV)) % int'(DIGITS)));
      chk($sformatf("scan an k%0d", k), 32'(seg_an_out), 32'(an_exp));
      chk($sformatf("scan seg k%0d", k), 32'(seg_data_out),
          ((k / int'(SCAN_DIV)) % int'(DIGITS) == 0) ? 32'hC0 : 32'hFF);
      chk("idle led", 32'(led_out), 32'h0);
    end

    // Conversion latency: busy for 18 cycles starting one cycle after the change
    @(negedge clk);
    score_in   = 16'd1234;
    busy_cnt   = 0;
    first_rise = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (conv_busy) begin
        busy_cnt++;
        if (first_rise < 0) first_rise = c;
      end
    end
    chk("busy length", 32'(busy_cnt), 32'd18);
    chk("busy start", 32'(first_rise), 32'd1);
    check_codes(model_codes(1234, 1'b1), "latency 1234");

    foreach (vecs[i]) begin
      apply_score(vecs[i].score, vecs[i].blank);
      check_codes(vecs[i].codes, $sformatf("vec%0d", i));
    end

    // Rapid score changes: display settles to the last one
    blank_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      score_in = SCORE_W'(100 + 1111 * i);
      @(negedge clk);
    end
    repeat (2 * (SCORE_W + 3) + 2) @(negedge clk);
    chk("glitch busy", 32'(conv_busy), 32'd0);
    check_codes(model_codes(100 + 1111 * 4, 1'b1), "glitch");

    for (int i = 0; i < 20; i++) begin
      s = (i % 3 == 0) ? int'($urandom_range(0, 120)) : int'($urandom_range(0, 65535));
      b = 1'($urandom_range(0, 1));
      apply_score(s, b);
      check_codes(model_codes(s, b), $sformatf("rand%0d s%0d b%0d", i, s, b));
    end

    led_run(2'b01, 70);
    led_run(2'b10, 40);
    led_run(2'b11, 40);
    led_run(2'b00, 10);
    for (int i = 0; i < 10; i++) begin
      led_run(2'($urandom_range(0, 3)), int'($urandom_range(3, 30)));
    end

    // Reset in the middle of a conversion
    led_run(2'b01, 5);
    @(negedge clk);
    score_in = 16'd4321;
    blank_en = 1'b1;
    repeat (8) @(negedge clk);
    chk("busy mid shift", 32'(conv_busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset an", 32'(seg_an_out), 32'hF);
    chk("async reset seg", 32'(seg_data_out), 32'hFF);
    chk("async reset led", 32'(led_out), 32'h0);
    chk("async reset busy", 32'(conv_busy), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (SCORE_W + 5) @(negedge clk);
    chk("reconvert busy", 32'(conv_busy), 32'd0);
    check_codes(model_codes(4321, 1'b1), "reconvert");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
